// File: rtl/key_encoder_pkg.sv
// rtl/key_encoder_pkg.sv - shared types, codes and helpers for the key encoder
package key_encoder_pkg;

  typedef enum logic {IDLE, HELD} key_state_t;

  localparam logic [2:0] ENABLE_ACTIVE = 3'd4;
  localparam logic [2:0] ENABLE_IDLE   = 3'd0;
  localparam logic [7:0] KEYS_RELEASED = 8'hff;

  // Index of the lowest-numbered pressed (low) key; 0 when none is pressed.
  function automatic logic [2:0] lowest_low(input logic [7:0] keys);
    lowest_low = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!keys[i]) lowest_low = 3'(i);
    end
  endfunction

  // Number of pressed (low) keys.
  function automatic logic [3:0] low_count(input logic [7:0] keys);
    low_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      low_count = low_count + {3'd0, ~keys[i]};
    end
  endfunction

endpackage

// File: rtl/key_encoder_if.sv
// rtl/key_encoder_if.sv - key inputs and encoded outputs of the key encoder
interface key_encoder_if;

  logic [7:0] key;
  logic [2:0] switch;
  logic [2:0] enable;
  logic       press;
  logic       multi;

  // Board/stimulus side: drives the raw keys, observes the code.
  modport master (
    output key,
    input  switch,
    input  enable,
    input  press,
    input  multi
  );

  // Encoder side.
  modport slave (
    input  key,
    output switch,
    output enable,
    output press,
    output multi
  );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchroniser plus stable-count debouncer for one active-low key
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Shift the raw key through the synchroniser; reset value means released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Accept a new level only after it differs from deb on DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      deb <= 1'b1;
    end else if (sync != deb) begin
      if (cnt == CNT_LAST) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/key_encoder.sv
// rtl/key_encoder.sv - debounced 8-key to {switch, enable} encoder; KEY_ENCODER_LATCH_EN keeps enable on release
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  key_encoder_if.slave  bus
);

  logic [7:0] deb;

  key_state_t state, state_d;
  logic [2:0] switch_q, switch_d;
  logic [2:0] enable_q, enable_d;
  logic       press_q, press_d;
  logic       multi_q, multi_d;

  for (genvar g = 0; g < 8; g++) begin : g_key
    key_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk(clk),
      .rst(rst),
      .raw(bus.key[g]),
      .deb(deb[g])
    );
  end

  // Register state and all outputs so nothing combinational reaches the pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      switch_q <= 3'd0;
      enable_q <= ENABLE_IDLE;
      press_q  <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      state    <= state_d;
      switch_q <= switch_d;
      enable_q <= enable_d;
      press_q  <= press_d;
      multi_q  <= multi_d;
    end
  end

  // Accept the lowest pressed key from IDLE; in HELD wait only for that key to release.
  always_comb begin
    state_d  = state;
    switch_d = switch_q;
    enable_d = enable_q;
    press_d  = 1'b0;
    multi_d  = (low_count(deb) > 4'd1);
    case (state)
      IDLE: begin
        if (deb != KEYS_RELEASED) begin
          switch_d = lowest_low(deb);
          enable_d = ENABLE_ACTIVE;
          press_d  = 1'b1;
          state_d  = HELD;
        end
      end
      HELD: begin
        if (deb[switch_q]) begin
          state_d = IDLE;
`ifdef KEY_ENCODER_LATCH_EN
          enable_d = enable_q;
`else
          enable_d = ENABLE_IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.switch = switch_q;
  assign bus.enable = enable_q;
  assign bus.press  = press_q;
  assign bus.multi  = multi_q;

endmodule

// File: tb/tb_key_encoder.sv
// tb/tb_key_encoder.sv - directed self-checking bench for key_encoder
module tb_key_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef KEY_ENCODER_LATCH_EN
  localparam logic [2:0] REL_EN = 3'd4;
`else
  localparam logic [2:0] REL_EN = 3'd0;
`endif

  key_encoder_if bus ();

  key_encoder u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [2:0] sw, input logic [2:0] en,
                      input logic pr, input logic mu);
    chk({tag, ".switch"}, {5'd0, bus.switch}, {5'd0, sw});
    chk({tag, ".enable"}, {5'd0, bus.enable}, {5'd0, en});
    chk({tag, ".press"},  {7'd0, bus.press},  {7'd0, pr});
    chk({tag, ".multi"},  {7'd0, bus.multi},  {7'd0, mu});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    bus.key = 8'h00;

    // 1: reset held with every key pressed
    step(2);
    outs("rst_a", 3'd0, 3'd0, 1'b0, 1'b0);
    step(3);
    outs("rst_b", 3'd0, 3'd0, 1'b0, 1'b0);
    bus.key = 8'hff;
    step(1);
    rst = 1'b1;
    step(3);
    outs("idle", 3'd0, 3'd0, 1'b0, 1'b0);

    // 2: key 5 pressed, 7-cycle latency on press and release
    bus.key = 8'hdf;
    step(6);
    outs("k5_e6", 3'd0, 3'd0, 1'b0, 1'b0);
    step(1);
    outs("k5_e7", 3'd5, 3'd4, 1'b1, 1'b0);
    step(1);
    outs("k5_e8", 3'd5, 3'd4, 1'b0, 1'b0);
    step(12);
    outs("k5_hold", 3'd5, 3'd4, 1'b0, 1'b0);
    bus.key = 8'hff;
    step(6);
    outs("k5_rel_e6", 3'd5, 3'd4, 1'b0, 1'b0);
    step(1);
    outs("k5_rel_e7", 3'd5, REL_EN, 1'b0, 1'b0);

    // 3: 3-cycle glitch on key 3 is rejected
    bus.key = 8'hf7;
    step(3);
    bus.key = 8'hff;
    for (int i = 0; i < 10; i++) begin
      step(1);
      outs("glitch", 3'd5, REL_EN, 1'b0, 1'b0);
    end

    // 4: keys 2 and 6 together, then key 2 released
    bus.key = 8'hbb;
    step(6);
    outs("k26_e6", 3'd5, REL_EN, 1'b0, 1'b0);
    step(1);
    outs("k26_e7", 3'd2, 3'd4, 1'b1, 1'b1);
    step(1);
    outs("k26_e8", 3'd2, 3'd4, 1'b0, 1'b1);
    step(4);
    bus.key = 8'hbf;
    step(6);
    outs("k2rel_e6", 3'd2, 3'd4, 1'b0, 1'b1);
    step(1);
    outs("k2rel_e7", 3'd2, REL_EN, 1'b0, 1'b0);
    step(1);
    outs("k6_e8", 3'd6, 3'd4, 1'b1, 1'b0);
    step(1);
    outs("k6_e9", 3'd6, 3'd4, 1'b0, 1'b0);
    bus.key = 8'hff;
    step(7);
    outs("k6_rel", 3'd6, REL_EN, 1'b0, 1'b0);

    // 5: asynchronous reset while a key is held, then re-acceptance
    bus.key = 8'hdf;
    step(10);
    outs("k5b_hold", 3'd5, 3'd4, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    outs("arst_now", 3'd0, 3'd0, 1'b0, 1'b0);
    step(2);
    outs("arst_held", 3'd0, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step(6);
    outs("rerel_e6", 3'd0, 3'd0, 1'b0, 1'b0);
    step(1);
    outs("rerel_e7", 3'd5, 3'd4, 1'b1, 1'b0);
    bus.key = 8'hff;
    step(7);
    outs("k5b_rel", 3'd5, REL_EN, 1'b0, 1'b0);

`ifdef KEY_ENCODER_LATCH_EN
    // 6: latched enable survives release; next key overwrites switch
    step(3);
    outs("latch_hold", 3'd5, 3'd4, 1'b0, 1'b0);
    bus.key = 8'hfd;
    step(6);
    outs("latch_k1_e6", 3'd5, 3'd4, 1'b0, 1'b0);
    step(1);
    outs("latch_k1_e7", 3'd1, 3'd4, 1'b1, 1'b0);
    bus.key = 8'hff;
    step(7);
    outs("latch_k1_rel", 3'd1, 3'd4, 1'b0, 1'b0);
`else
    step(3);
    outs("nolatch_idle", 3'd5, 3'd0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
